// File: rtl/hcu_scoreboard.sv
// Register scoreboard for the hazard control unit: tracks the pending write latency of each register
// and derives the pipeline stall, flush and forward controls.
module hcu_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int LAT_W    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_D,
   input  logic [REG_AW-1:0] rs1_D,
   input  logic [REG_AW-1:0] rs2_D,
   input  logic              rs1_used_D,
   input  logic              rs2_used_D,
   input  logic [REG_AW-1:0] rd_D,
   input  logic              rd_we_D,
   input  logic [LAT_W-1:0]  lat_D,
   input  logic              branch_taken_E,
   input  logic              mem_busy,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallW,
   output logic              FlushD,
   output logic              FlushE,
   output logic              fwdA_D,
   output logic              fwdB_D,
   output logic [REG_AW:0]   pending_cnt
);

   localparam int DEPTH = 1 << REG_AW;

   logic [DEPTH-1:0] pend, pend_nxt;
   logic [LAT_W-1:0] cnt     [DEPTH];
   logic [LAT_W-1:0] cnt_nxt [DEPTH];
   logic [REG_AW:0]  pop_nxt;
   logic             haz1, haz2, waw, stall, issue;

   assign haz1  = rs1_used_D & valid_D & (rs1_D != '0) & pend[rs1_D] & (cnt[rs1_D] != '0);
   assign haz2  = rs2_used_D & valid_D & (rs2_D != '0) & pend[rs2_D] & (cnt[rs2_D] != '0);
   assign waw   = valid_D & rd_we_D & (rd_D != '0) & pend[rd_D] & (cnt[rd_D] > lat_D);
   assign stall = (haz1 | haz2 | waw) & ~branch_taken_E;
   assign issue = valid_D & rd_we_D & (rd_D != '0) & ~mem_busy & ~branch_taken_E & ~stall;

   // A result with zero cycles left is on the result bus this cycle.
   assign fwdA_D = ~reset & rs1_used_D & (rs1_D != '0) & pend[rs1_D] & (cnt[rs1_D] == '0);
   assign fwdB_D = ~reset & rs2_used_D & (rs2_D != '0) & pend[rs2_D] & (cnt[rs2_D] == '0);

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallW = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (!reset) begin
         if (mem_busy) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallW = 1'b1;
         end else if (branch_taken_E) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // Only architectural registers above 0 are ever written; the rest of the array stays clear.
   always_comb begin
      pend_nxt = pend;
      cnt_nxt  = cnt;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (issue && (rd_D == REG_AW'(r))) begin
            pend_nxt[r] = 1'b1;
            cnt_nxt[r]  = lat_D;
         end else if (!mem_busy && pend[r]) begin
            if (cnt[r] != '0)
               cnt_nxt[r] = cnt[r] - LAT_W'(1);
            else
               pend_nxt[r] = 1'b0;
         end
      end
      pop_nxt = '0;
      for (int r = 0; r < DEPTH; r++)
         pop_nxt = pop_nxt + {{REG_AW{1'b0}}, pend_nxt[r]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend        <= '0;
         pending_cnt <= '0;
         for (int r = 0; r < DEPTH; r++)
            cnt[r] <= '0;
      end else begin
         pend        <= pend_nxt;
         pending_cnt <= pop_nxt;
         cnt         <= cnt_nxt;
      end
   end

endmodule
